// File: rtl/ldtu_frame_checker.sv
// LDTU receive-side frame checker: pops FIFO words, splits data from trailers and re-checks
// CRC-12, sample count, word count and frame number per frame, with saturating statistics.

module ldtu_frame_checker #(
  parameter int unsigned Nbits_32   = 32,
  parameter int unsigned crcBits    = 12,
  parameter int unsigned FrameWords = 50,
  parameter int unsigned ErrCntBits = 16
) (
  input  logic                  CLK,
  input  logic                  rst_b,
  input  logic                  enable,
  input  logic                  fallback,
  input  logic                  empty,
  input  logic [Nbits_32-1:0]   DATA_in,
  output logic                  read_en,
  output logic                  frame_done,
  output logic                  crc_error,
  output logic                  nsample_error,
  output logic                  nframe_error,
  output logic                  length_error,
  output logic [ErrCntBits-1:0] frame_count,
  output logic [ErrCntBits-1:0] err_count,
  output logic [ErrCntBits-1:0] fb_word_count,
  output logic                  synced
);

  localparam int unsigned NsBits = 8;
  localparam int unsigned WcBits = 6;
  localparam int unsigned NfBits = 8;

  typedef enum logic [1:0] {SYNC, RUN, FB} state_t;

  state_t              state;
  logic                word_valid;
  logic [crcBits-1:0]  crc_acc;
  logic [crcBits-1:0]  crc_next;
  logic [NsBits-1:0]   ns_acc;
  logic [NsBits-1:0]   ns_add;
  logic [WcBits-1:0]   wcnt;
  logic [NfBits-1:0]   exp_frame;
  logic                is_trailer;
  logic                is_data;
  logic [NsBits-1:0]   tr_ns;
  logic [crcBits-1:0]  tr_crc;
  logic [NfBits-1:0]   tr_nf;
  logic                c_err;
  logic                ns_err;
  logic                nf_err;
  logic                len_err;

  assign read_en    = enable & ~empty;
  assign is_trailer = word_valid && (DATA_in[31:28] == 4'b1101);
  assign is_data    = word_valid && !is_trailer;
  assign tr_ns      = DATA_in[27:20];
  assign tr_crc     = DATA_in[19:8];
  assign tr_nf      = DATA_in[7:0];

  assign c_err   = (tr_crc != crc_acc);
  assign ns_err  = (tr_ns != ns_acc);
  assign nf_err  = (tr_nf != exp_frame);
  assign len_err = (wcnt != WcBits'(FrameWords));

  CRC_calc #(
    .Nbits_32 (Nbits_32),
    .crcBits  (crcBits)
  ) u_crc (
    .reset  (rst_b),
    .data   (DATA_in),
    .crc    (crc_acc),
    .newcrc (crc_next)
  );

  // Samples carried by one data word, keyed on its header bits
  always_comb begin
    ns_add = '0;
    case (DATA_in[31:30])
      2'b01:   ns_add = NsBits'(5);
      2'b10:   ns_add = NsBits'(DATA_in[29:24]);
      2'b00:   ns_add = (DATA_in[31:26] == 6'b001010) ? NsBits'(2) : NsBits'(1);
      default: ns_add = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      state         <= SYNC;
      word_valid    <= 1'b0;
      crc_acc       <= '0;
      ns_acc        <= '0;
      wcnt          <= '0;
      exp_frame     <= '0;
      frame_done    <= 1'b0;
      crc_error     <= 1'b0;
      nsample_error <= 1'b0;
      nframe_error  <= 1'b0;
      length_error  <= 1'b0;
      frame_count   <= '0;
      err_count     <= '0;
      fb_word_count <= '0;
      synced        <= 1'b0;
    end else begin
      word_valid    <= read_en;
      frame_done    <= 1'b0;
      crc_error     <= 1'b0;
      nsample_error <= 1'b0;
      nframe_error  <= 1'b0;
      length_error  <= 1'b0;
      if (fallback) begin
        // Fallback overrides everything; any partial frame is dropped
        state   <= FB;
        synced  <= 1'b0;
        crc_acc <= '0;
        ns_acc  <= '0;
        wcnt    <= '0;
        if (word_valid && (fb_word_count != '1)) fb_word_count <= fb_word_count + 1'b1;
      end else begin
        unique case (state)
          SYNC: begin
            if (is_trailer) begin
              exp_frame <= tr_nf + 1'b1;
              state     <= RUN;
              synced    <= 1'b1;
            end
          end
          RUN: begin
            if (is_trailer) begin
              frame_done    <= 1'b1;
              crc_error     <= c_err;
              nsample_error <= ns_err;
              nframe_error  <= nf_err;
              length_error  <= len_err;
              crc_acc       <= '0;
              ns_acc        <= '0;
              wcnt          <= '0;
              exp_frame     <= tr_nf + 1'b1;
              if (frame_count != '1) frame_count <= frame_count + 1'b1;
              if ((c_err || ns_err || nf_err || len_err) && (err_count != '1))
                err_count <= err_count + 1'b1;
            end else if (is_data) begin
              crc_acc <= crc_next;
              ns_acc  <= ns_acc + ns_add;
              if (wcnt != '1) wcnt <= wcnt + 1'b1;
            end
          end
          FB: begin
            // CU restarts NFrame after fallback, so resynchronise
            crc_acc <= '0;
            ns_acc  <= '0;
            wcnt    <= '0;
            state   <= SYNC;
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule

// CRC-12 (x^12+x^11+x^3+x^2+x+1) over one word, MSB first; output forced to 0 while reset is low.
module CRC_calc #(
  parameter int unsigned Nbits_32 = 32,
  parameter int unsigned crcBits  = 12
) (
  input  logic                reset,
  input  logic [Nbits_32-1:0] data,
  input  logic [crcBits-1:0]  crc,
  output logic [crcBits-1:0]  newcrc
);

  localparam logic [crcBits-1:0] Poly = crcBits'(12'h80F);

  logic [crcBits-1:0]  c;
  logic [Nbits_32-1:0] d;

  always_comb begin
    c = crc;
    d = data;
    for (int i = 0; i < int'(Nbits_32); i++) begin
      if (c[crcBits-1] ^ d[Nbits_32-1]) c = (c << 1) ^ Poly;
      else                              c = c << 1;
      d = d << 1;
    end
    newcrc = reset ? c : '0;
  end

endmodule

// File: tb/tb_ldtu_frame_checker.sv
// Scoreboard bench for ldtu_frame_checker: FIFO model feeds directed frames, monitor checks each frame_done.

module tb_ldtu_frame_checker;

  logic        CLK = 1'b0;
  logic        rst_b;
  logic        enable;
  logic        fallback;
  logic        empty;
  logic [31:0] DATA_in;
  logic        read_en;
  logic        frame_done;
  logic        crc_error;
  logic        nsample_error;
  logic        nframe_error;
  logic        length_error;
  logic [15:0] frame_count;
  logic [15:0] err_count;
  logic [15:0] fb_word_count;
  logic        synced;

  typedef struct {
    logic [3:0]  flags;
    logic [15:0] fc;
    logic [15:0] ec;
  } exp_t;

  logic [31:0] tx_q[$];
  exp_t        sb_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  logic        gap_mode = 1'b0;
  logic [15:0] exp_fc = '0;
  logic [15:0] exp_ec = '0;

  ldtu_frame_checker dut (
    .CLK           (CLK),
    .rst_b         (rst_b),
    .enable        (enable),
    .fallback      (fallback),
    .empty         (empty),
    .DATA_in       (DATA_in),
    .read_en       (read_en),
    .frame_done    (frame_done),
    .crc_error     (crc_error),
    .nsample_error (nsample_error),
    .nframe_error  (nframe_error),
    .length_error  (length_error),
    .frame_count   (frame_count),
    .err_count     (err_count),
    .fb_word_count (fb_word_count),
    .synced        (synced)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Reference CRC-12, polynomial 0x80F, MSB first
  function automatic logic [11:0] crc_step(input logic [11:0] c_in, input logic [31:0] w);
    logic [11:0] c;
    logic [31:0] d;
    logic        fb;
    c = c_in;
    d = w;
    for (int i = 0; i < 32; i++) begin
      fb = c[11] ^ d[31];
      c  = {c[10:0], 1'b0} ^ (fb ? 12'h80F : 12'h000);
      d  = {d[30:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [11:0] crc_rep(input logic [11:0] c_in, input logic [31:0] w, input int n);
    logic [11:0] c;
    c = c_in;
    for (int i = 0; i < n; i++) c = crc_step(c, w);
    return c;
  endfunction

  task automatic send_data(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) tx_q.push_back(w);
  endtask

  task automatic send_trailer(input logic [7:0] ns, input logic [11:0] crc, input logic [7:0] nf);
    tx_q.push_back({4'hD, ns, crc, nf});
  endtask

  // flags = {crc, nsample, nframe, length}
  task automatic expect_frame(input logic [3:0] flags);
    exp_t e;
    if (exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
    if ((flags != 4'b0) && (exp_ec != 16'hFFFF)) exp_ec = exp_ec + 16'd1;
    e.flags = flags;
    e.fc    = exp_fc;
    e.ec    = exp_ec;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((tx_q.size() != 0) && (b < 3000)) begin
      @(negedge CLK);
      b++;
    end
    if (tx_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: actual=%0d words left required=0", tx_q.size());
    end
    repeat (5) @(negedge CLK);
  endtask

  // FIFO model: read data appears the cycle after read_en
  always @(negedge CLK) begin
    if (read_en && (tx_q.size() != 0)) DATA_in = tx_q.pop_front();
    cyc++;
    empty = (tx_q.size() == 0) || (gap_mode && ((cyc % 3) == 0));
  end

  // Monitor: every frame_done is matched against the next scoreboard entry
  always @(negedge CLK) begin
    exp_t e;
    if (rst_b && frame_done) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_frame_done: actual=1 required=0 (frame_count=%0d)", frame_count);
      end else begin
        e = sb_q.pop_front();
        check("frame_flags", 32'({crc_error, nsample_error, nframe_error, length_error}), 32'(e.flags));
        check("frame_count", 32'(frame_count), 32'(e.fc));
        check("err_count", 32'(err_count), 32'(e.ec));
      end
    end
  end

  initial begin
    repeat (60000) @(posedge CLK);
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] crc_a;
    logic [11:0] crc_b;
    logic [11:0] crc_m;
    rst_b    = 1'b0;
    enable   = 1'b0;
    fallback = 1'b0;
    empty    = 1'b1;
    DATA_in  = '0;
    repeat (3) @(negedge CLK);
    check("rst_pulses", 32'({frame_done, crc_error, nsample_error, nframe_error, length_error}), 32'd0);
    check("rst_counters", 32'(frame_count | err_count | fb_word_count), 32'd0);
    check("rst_synced", 32'(synced), 32'd0);
    check("rst_read_en", 32'(read_en), 32'd0);
    rst_b = 1'b1;
    @(negedge CLK);
    enable = 1'b1;

    // Clean frame after sync
    crc_a = crc_rep(12'h000, 32'h8000_0003, 50);
    send_trailer(8'h00, 12'h000, 8'h07);
    drain();
    check("s1_synced", 32'(synced), 32'd1);
    check("s1_no_frame_yet", 32'(frame_count), 32'd0);
    send_data(32'h8000_0003, 50);
    expect_frame(4'b0000);
    send_trailer(8'h00, crc_a, 8'h08);
    drain();
    check("s1_frame_count", 32'(frame_count), 32'd1);

    // Sample count 50*5 = 0xFA, then a single flipped data bit
    crc_b = crc_rep(12'h000, 32'h4000_0000, 50);
    send_data(32'h4000_0000, 50);
    expect_frame(4'b0000);
    send_trailer(8'hFA, crc_b, 8'h09);
    send_data(32'h4000_0000, 49);
    send_data(32'h4000_0001, 1);
    expect_frame(4'b1000);
    send_trailer(8'hFA, crc_b, 8'h0A);
    drain();
    check("s2_err_count", 32'(err_count), 32'd1);

    // Frame number 0x0D while 0x0B expected, then re-aligned 0x0E passes
    send_data(32'h8000_0003, 50);
    expect_frame(4'b0010);
    send_trailer(8'h00, crc_a, 8'h0D);
    send_data(32'h8000_0003, 50);
    expect_frame(4'b0000);
    send_trailer(8'h00, crc_a, 8'h0E);

    // Short frame, over-long frame (wcnt saturates), back-to-back trailer
    send_data(32'h8000_0003, 49);
    expect_frame(4'b0001);
    send_trailer(8'h00, crc_rep(12'h000, 32'h8000_0003, 49), 8'h0F);
    send_data(32'h8000_0003, 70);
    expect_frame(4'b0001);
    send_trailer(8'h00, crc_rep(12'h000, 32'h8000_0003, 70), 8'h10);
    expect_frame(4'b0001);
    send_trailer(8'h00, 12'h000, 8'h11);

    // Mixed headers: 10*31 + 20*2 + 10*1 + 10*0 = 360 -> 0x68 mod 256
    crc_m = crc_rep(12'h000, 32'h9F00_0000, 10);
    crc_m = crc_rep(crc_m, 32'h2800_0000, 20);
    crc_m = crc_rep(crc_m, 32'h1000_0000, 10);
    crc_m = crc_rep(crc_m, 32'hC500_0000, 10);
    send_data(32'h9F00_0000, 10);
    send_data(32'h2800_0000, 20);
    send_data(32'h1000_0000, 10);
    send_data(32'hC500_0000, 10);
    expect_frame(4'b0000);
    send_trailer(8'h68, crc_m, 8'h12);
    drain();
    check("s4_frame_count", 32'(frame_count), 32'd9);
    check("s4_err_count", 32'(err_count), 32'd5);

    // Fallback mid-frame: 30 words counted, no checks, resync needed
    send_data(32'h8000_0003, 20);
    drain();
    fallback = 1'b1;
    repeat (2) @(negedge CLK);
    check("s5_synced_in_fb", 32'(synced), 32'd0);
    send_data(32'h8000_0003, 15);
    send_trailer(8'h00, 12'h000, 8'h13);
    send_data(32'h8000_0003, 14);
    drain();
    fallback = 1'b0;
    repeat (3) @(negedge CLK);
    check("s5_fb_word_count", 32'(fb_word_count), 32'd30);
    check("s5_synced_after", 32'(synced), 32'd0);
    check("s5_frame_count", 32'(frame_count), 32'd9);
    send_trailer(8'h00, 12'h000, 8'h00);
    drain();
    check("s5_resynced", 32'(synced), 32'd1);
    send_data(32'h8000_0003, 50);
    expect_frame(4'b0000);
    send_trailer(8'h00, crc_a, 8'h01);
    drain();

    // Asynchronous reset mid-frame
    send_data(32'h8000_0003, 20);
    repeat (8) @(negedge CLK);
    #2;
    enable = 1'b0;
    rst_b  = 1'b0;
    #1;
    check("s6_rst_pulses", 32'({frame_done, crc_error, nsample_error, nframe_error, length_error}), 32'd0);
    check("s6_rst_frame_count", 32'(frame_count), 32'd0);
    check("s6_rst_err_count", 32'(err_count), 32'd0);
    check("s6_rst_fb_count", 32'(fb_word_count), 32'd0);
    check("s6_rst_synced", 32'(synced), 32'd0);
    tx_q.delete();
    sb_q.delete();
    exp_fc = '0;
    exp_ec = '0;
    @(negedge CLK);
    rst_b = 1'b1;
    @(negedge CLK);
    gap_mode = 1'b1;
    enable   = 1'b1;
    send_trailer(8'h00, 12'h000, 8'h20);
    send_data(32'h8000_0003, 50);
    expect_frame(4'b0000);
    send_trailer(8'h00, crc_a, 8'h21);
    drain();
    check("s6_frame_count", 32'(frame_count), 32'd1);
    check("s6_err_count", 32'(err_count), 32'd0);
    check("sb_all_seen", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
